// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Two-requester write-port arbiter in front of a register file write port.
//   Requester 0 is ALU writeback and requester 1 is load writeback. The grant
//   is combinational from the VALIDs and the priority state. The accepted
//   request is registered into A3/WD3/WE3 one cycle later.
//
//   Optional feature: define RR_ARB_EN for round-robin arbitration on conflict.
//   When it is undefined, requester 0 has fixed priority. last_grant is
//   tracked in both builds.
//
// Ports
//   CLK, RST                  clock; asynchronous active-low reset
//   REQn_VALID/ADDR/DATA      requester n write request (held until accepted)
//   REQn_READY                requester n accepted this cycle
//   A3, WD3, WE3              registered register-file write port
//   CONFLICT_CNT              saturating count of cycles with both requesters valid
module regfile_wr_arbiter #(
  parameter int RegFileAdd    = 5,
  parameter int RegFile_width = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ0_VALID,
  input  logic [RegFileAdd-1:0]    REQ0_ADDR,
  input  logic [RegFile_width-1:0] REQ0_DATA,
  output logic                     REQ0_READY,
  input  logic                     REQ1_VALID,
  input  logic [RegFileAdd-1:0]    REQ1_ADDR,
  input  logic [RegFile_width-1:0] REQ1_DATA,
  output logic                     REQ1_READY,
  output logic [RegFileAdd-1:0]    A3,
  output logic [RegFile_width-1:0] WD3,
  output logic                     WE3,
  output logic [15:0]              CONFLICT_CNT
);

`ifdef RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic                     valid;
    logic [RegFileAdd-1:0]    addr;
    logic [RegFile_width-1:0] data;
  } req_t;

  req_t req0, req1, acc;
  logic conflict, gnt0, gnt1, xfer;
  logic last_grant;  // index of the most recently granted requester

  assign req0 = {REQ0_VALID, REQ0_ADDR, REQ0_DATA};
  assign req1 = {REQ1_VALID, REQ1_ADDR, REQ1_DATA};

  always_comb begin
    conflict = req0.valid & req1.valid;
    gnt0     = req0.valid;
    gnt1     = req1.valid;
    if (conflict) begin
      // Round-robin grants whichever requester did not win last time.
      // Fixed priority always grants requester 0.
      gnt0 = RR ? last_grant  : 1'b1;
      gnt1 = RR ? !last_grant : 1'b0;
    end
  end

  // Gating with RST keeps both READYs low while reset is asserted.
  assign REQ0_READY = RST & gnt0;
  assign REQ1_READY = RST & gnt1;
  assign xfer       = REQ0_READY | REQ1_READY;
  assign acc        = REQ0_READY ? req0 : req1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      A3           <= '0;
      WD3          <= '0;
      WE3          <= 1'b0;
      CONFLICT_CNT <= '0;
      last_grant   <= 1'b1;  // so the first conflict after reset goes to 0
    end else begin
      if (xfer) begin
        A3         <= acc.addr;
        WD3        <= acc.data;
        WE3        <= |acc.addr;  // register 0 is hardwired: accept, don't write
        last_grant <= REQ1_READY;
      end else begin
        WE3 <= 1'b0;
      end
      if (conflict && CONFLICT_CNT != 16'hFFFF)
        CONFLICT_CNT <= CONFLICT_CNT + 16'd1;
    end
  end

endmodule
